gpr_writeback: RTL
==================

# gpr_writeback

Write-side controller for the general-purpose register file. It owns the single GPR write port (`reg_write`/`rd`/`data_write`) and merges two result sources: single-cycle ALU results and in-order load responses from data memory. Results that cannot write immediately are buffered. A load-tag queue and a hazard check let decode stall while any source register has a write still in flight. It sits between execute/memory and the register file.

## Interface
- `ALU_DEPTH`, 2: entries in the ALU result holding buffer (power of 2, ≥2).
- `LDQ_DEPTH`, 4: maximum outstanding loads (power of 2, ≥2).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `alu_valid` in 1: ALU result offered this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU result accepted when `alu_valid & alu_ready`.
- `ld_issue` in 1: load issued to memory; push `ld_issue_rd` into the load-tag queue.
- `ld_issue_rd` in 5: load destination register.
- `ld_issue_ready` out 1: load-tag queue not full.
- `ld_valid` in 1: load response returning, in issue order.
- `ld_data` in 32: load response data.
- `rs1`, `rs2` in 5 each: decode source registers to check.
- `chk_rd` in 5: decode destination register to check for WAW.
- `stall` out 1: combinational hazard flag to decode.
- `reg_write` out 1: registered write enable to the GPR.
- `rd` out 5: registered GPR write address.
- `data_write` out 32: registered GPR write data.
- `ld_err` out 1: sticky flag, set on a load response with an empty tag queue.

## Operation
- Each cycle at most one write is selected. Priority:
  1. Load response: head of the tag queue plus `ld_data`.
  2. ALU buffer head.
  3. Incoming ALU result, which bypasses the buffer only when the buffer is empty.
- The selected write is registered onto `reg_write`/`rd`/`data_write` for one cycle. `reg_write` is 0 in cycles with no selection.
- Writes with destination 0 are consumed (popped/accepted) but produce `reg_write`=0.
- An incoming ALU result not selected this cycle is pushed into the ALU buffer.
- `alu_ready` = buffer not full. This is a registered-state function and does not account for a same-cycle pop.
- A push and a pop on the ALU buffer in the same cycle are both legal; occupancy is unchanged.
- `ld_issue & ld_issue_ready` pushes the tag. `ld_issue` while not ready is ignored. A push and pop in the same cycle are legal.
- `ld_valid` with an empty tag queue: the response is dropped, no write occurs, and `ld_err` is set. `ld_err` clears only on reset.
- `ld_valid` always takes the write port, so the ALU buffer drains only in cycles without a load response.
- `stall` = 1 if any nonzero register among `rs1`, `rs2` matches a valid ALU-buffer entry, a valid tag-queue entry, or the currently registered `rd` with `reg_write`=1.
  - The GPR write lands at the next edge, so the final match covers the one-cycle write window.
- `stall` is also 1 if nonzero `chk_rd` matches any valid tag-queue entry (WAW against an outstanding load).
- Register 0 never causes a stall.
- Queue pointers wrap modulo depth. Occupancy counters are `log2(DEPTH)+1` bits wide.

## Timing
- Reset values:
  - `reg_write`=0, `rd`=0, `data_write`=0, `ld_err`=0.
  - Both queues empty, so `alu_ready`=1 and `ld_issue_ready`=1.
  - `stall`=0 for any inputs.
- ALU result via bypass: `reg_write` is high in the cycle after acceptance.
- Load response: `reg_write` is high in the cycle after `ld_valid`.
- A buffered ALU entry writes in the first cycle after it becomes head with `ld_valid`=0.
- `stall`, `alu_ready` and `ld_issue_ready` are combinational from registered state and current inputs. There are no registered handshake outputs.
- Reset asserted mid-operation discards all buffered and pending writes. `reg_write` drops to 0 asynchronously.

## Test plan
- ALU result, no contention: `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234 → next cycle `reg_write`=1, `rd`=5, `data_write`=0x1234. `stall` is 1 for `rs1`=5 during that write cycle and 0 afterwards.
- Load/ALU collision:
  - Stimulus: `ld_issue_rd`=7, later `ld_valid` with `ld_data`=0xAA in the same cycle as an ALU result to x3 = 0x55.
  - Required response: first write x7=0xAA, next cycle x3=0x55.
  - `alu_ready` stays 1 throughout.
- Buffer full:
  - Stimulus: `ld_valid` held high for 4 cycles while ALU offers each cycle.
  - Required response: after 2 ALU acceptances `alu_ready`=0.
  - When `ld_valid` drops, the buffered ALU results write in order on consecutive cycles.
- Load queue full and hazard:
  - Stimulus: issue 4 loads to x1..x4 → `ld_issue_ready`=0. A fifth `ld_issue` is ignored.
  - Required response: `rs2`=3 gives `stall`=1, and `chk_rd`=2 gives `stall`=1 until x2's response.
  - Responses write x1..x4 in order.
- x0 and error handling:
  - An ALU result to x0 is accepted with `reg_write`=0, and `rs1`=0 never stalls.
  - `ld_valid` with an empty queue gives `ld_err`=1, sticky, with no write.
- Async reset mid-stream: with 2 buffered entries and 3 tags, pull `reset` low between edges → outputs clear immediately. After release there are no spurious writes, `stall`=0, and both ready outputs are 1.

Source files
------------

// File: rtl/gpr_writeback.sv
// GPR write-port controller: merges in-order load responses and ALU results onto one
// registered write port, buffering ALU results and tracking outstanding load tags for hazards.
module gpr_writeback #(
  parameter int ALU_DEPTH = 2,
  parameter int LDQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  output logic        ld_issue_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  chk_rd,
  output logic        stall,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [31:0] data_write,
  output logic        ld_err
);
  localparam int AW = $clog2(ALU_DEPTH);
  localparam int LW = $clog2(LDQ_DEPTH);
  localparam logic [AW:0] ALU_FULL = ALU_DEPTH[AW:0];
  localparam logic [LW:0] LDQ_FULL = LDQ_DEPTH[LW:0];

  // Handshakes: alu result transfers on alu_valid & alu_ready, load tag on
  // ld_issue & ld_issue_ready; ld_valid has no back-pressure and must be taken.
  logic [4:0]    alu_rd_q   [ALU_DEPTH];
  logic [31:0]   alu_data_q [ALU_DEPTH];
  logic [AW-1:0] alu_wptr_q, alu_wptr_d, alu_rptr_q, alu_rptr_d;
  logic [AW:0]   alu_cnt_q, alu_cnt_d;
  logic [4:0]    ldq_rd_q   [LDQ_DEPTH];
  logic [LW-1:0] ldq_wptr_q, ldq_wptr_d, ldq_rptr_q, ldq_rptr_d;
  logic [LW:0]   ldq_cnt_q, ldq_cnt_d;
  logic          reg_write_q, reg_write_d, ld_err_q, ld_err_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   data_q, data_d;

  logic          alu_acc, alu_push, alu_pop, alu_bypass, ldq_push, ldq_pop, sel_any;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic [AW-1:0] aoff;
  logic [LW-1:0] loff;

  assign alu_ready      = (alu_cnt_q != ALU_FULL);
  assign ld_issue_ready = (ldq_cnt_q != LDQ_FULL);
  assign reg_write      = reg_write_q;
  assign rd             = rd_q;
  assign data_write     = data_q;
  assign ld_err         = ld_err_q;

  function automatic logic src_hit(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
    return (r != 5'd0) && ((r == a) || (r == b));
  endfunction

  // Write selection: a load response always owns the port, even a dropped one.
  always_comb begin
    alu_acc    = alu_valid & alu_ready;
    ldq_push   = ld_issue & ld_issue_ready;
    ldq_pop    = ld_valid & (ldq_cnt_q != '0);
    alu_pop    = 1'b0;
    alu_bypass = 1'b0;
    sel_any    = 1'b0;
    sel_rd     = '0;
    sel_data   = '0;
    if (ld_valid) begin
      sel_any  = ldq_pop;
      sel_rd   = ldq_rd_q[ldq_rptr_q];
      sel_data = ld_data;
    end else if (alu_cnt_q != '0) begin
      alu_pop  = 1'b1;
      sel_any  = 1'b1;
      sel_rd   = alu_rd_q[alu_rptr_q];
      sel_data = alu_data_q[alu_rptr_q];
    end else if (alu_acc) begin
      alu_bypass = 1'b1;
      sel_any    = 1'b1;
      sel_rd     = alu_rd;
      sel_data   = alu_data;
    end
    alu_push = alu_acc & ~alu_bypass;

    alu_wptr_d  = alu_push ? alu_wptr_q + 1'b1 : alu_wptr_q;
    alu_rptr_d  = alu_pop  ? alu_rptr_q + 1'b1 : alu_rptr_q;
    alu_cnt_d   = alu_cnt_q + {{AW{1'b0}}, alu_push} - {{AW{1'b0}}, alu_pop};
    ldq_wptr_d  = ldq_push ? ldq_wptr_q + 1'b1 : ldq_wptr_q;
    ldq_rptr_d  = ldq_pop  ? ldq_rptr_q + 1'b1 : ldq_rptr_q;
    ldq_cnt_d   = ldq_cnt_q + {{LW{1'b0}}, ldq_push} - {{LW{1'b0}}, ldq_pop};
    reg_write_d = sel_any & (sel_rd != 5'd0);
    rd_d        = sel_any ? sel_rd : rd_q;
    data_d      = sel_any ? sel_data : data_q;
    ld_err_d    = ld_err_q | (ld_valid & (ldq_cnt_q == '0));
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    stall = reg_write_q && src_hit(rd_q, rs1, rs2);
    aoff  = '0;
    loff  = '0;
    for (int i = 0; i < ALU_DEPTH; i++) begin
      aoff = AW'(i) - alu_rptr_q;
      if (({1'b0, aoff} < alu_cnt_q) && src_hit(alu_rd_q[i], rs1, rs2)) stall = 1'b1;
    end
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      loff = LW'(i) - ldq_rptr_q;
      if ({1'b0, loff} < ldq_cnt_q) begin
        if (src_hit(ldq_rd_q[i], rs1, rs2)) stall = 1'b1;
        if ((chk_rd != 5'd0) && (chk_rd == ldq_rd_q[i])) stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_wptr_q  <= '0;
      alu_rptr_q  <= '0;
      alu_cnt_q   <= '0;
      ldq_wptr_q  <= '0;
      ldq_rptr_q  <= '0;
      ldq_cnt_q   <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      ld_err_q    <= 1'b0;
    end else begin
      alu_wptr_q  <= alu_wptr_d;
      alu_rptr_q  <= alu_rptr_d;
      alu_cnt_q   <= alu_cnt_d;
      ldq_wptr_q  <= ldq_wptr_d;
      ldq_rptr_q  <= ldq_rptr_d;
      ldq_cnt_q   <= ldq_cnt_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      ld_err_q    <= ld_err_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_rd_q[alu_wptr_q]   <= alu_rd;
      alu_data_q[alu_wptr_q] <= alu_data;
    end
    if (ldq_push) ldq_rd_q[ldq_wptr_q] <= ld_issue_rd;
  end
endmodule
